adder_arbiter: RTL and testbench

//  Shares one 64-bit carry-select adder (CSA_64bit) between NREQ requesters.

---
 rtl/adder_arb_pkg.sv | 21 ++
 rtl/adder_arbiter_rr_arbiter.sv | 47 ++++
 rtl/adder_arbiter.sv | 168 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types for the round-robin front end of the shared 64-bit adder.
// Beat struct carries one accepted request from the grant stage to S1.
package adder_arb_pkg;

    localparam int W_DEFAULT = 64;
    localparam int NREQ_MAX  = 8;
    localparam int IDW_MAX   = $clog2(NREQ_MAX);

    typedef logic [IDW_MAX-1:0]   id_t;
    typedef logic [W_DEFAULT-1:0] operand_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
        logic     cin;
        id_t      id;
        logic     first;
        logic     last;
    } beat_t;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after the pointer.
// The pointer moves to the granted index only when the grant is taken.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] ptr;
    logic           found;

    // two passes: indices above the pointer first, then wrap from zero
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDW'(i) > ptr)) begin
                grant[i] = 1'b1;
                gnt_id   = IDW'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (IDW'(i) <= ptr)) begin
                grant[i] = 1'b1;
                gnt_id   = IDW'(i);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (take && found) begin
            ptr <= gnt_id;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder between NREQ requesters: RR grant, S1 operands, S2 response.
// Define ADDER_ARB_CHAIN_EN for locked multi-beat adds with carry chaining.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = W_DEFAULT,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_last,
    output logic [W-1:0]      adder_a,
    output logic [W-1:0]      adder_b,
    output logic              adder_cin,
    input  logic [W-1:0]      adder_sum,
    input  logic              adder_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last
);

    logic            adv2;
    logic            acc1;
    logic            hs;
    logic [NREQ-1:0] req_mask;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;

    logic            s1_vld;
    beat_t           s1_q;
    beat_t           beat_d;

    operand_t        sel_a;
    operand_t        sel_b;
    logic            sel_cin;
    logic            sel_last;
    logic            beat_first;
    logic            beat_last;

    assign adv2      = !rsp_valid || rsp_ready;
    assign acc1      = !s1_vld || adv2;
    assign req_ready = grant & {NREQ{acc1}};
    assign hs        = |(req_valid & req_ready);

    rr_arbiter #(
        .NREQ   (NREQ)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req_mask),
        .take   (acc1),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_cin  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a    = operand_t'(req_a[i*W +: W]);
                sel_b    = operand_t'(req_b[i*W +: W]);
                sel_cin  = req_cin[i];
                sel_last = req_last[i];
            end
        end
    end

`ifdef ADDER_ARB_CHAIN_EN
    logic           locked;
    logic [IDW-1:0] lock_id;
    logic           chain_carry;

    // while a chain is open only its owner may be granted
    always_comb begin
        req_mask = req_valid;
        if (locked) begin
            req_mask = req_valid & (NREQ'(1) << lock_id);
        end
    end

    assign beat_first = !locked;
    assign beat_last  = sel_last;
    assign adder_cin  = s1_q.first ? s1_q.cin : chain_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (hs) begin
            locked  <= !sel_last;
            lock_id <= gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_carry <= 1'b0;
        end else if (s1_vld && adv2) begin
            chain_carry <= adder_cout;
        end
    end
`else
    assign req_mask   = req_valid;
    assign beat_first = 1'b1;
    assign beat_last  = 1'b1;
    assign adder_cin  = s1_q.cin;
`endif

    always_comb begin
        beat_d       = '0;
        beat_d.a     = sel_a;
        beat_d.b     = sel_b;
        beat_d.cin   = sel_cin;
        beat_d.id    = id_t'(gnt_id);
        beat_d.first = beat_first;
        beat_d.last  = beat_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (acc1) begin
            s1_vld <= hs;
            if (hs) begin
                s1_q <= beat_d;
            end
        end
    end

    assign adder_a = s1_q.a[W-1:0];
    assign adder_b = s1_q.b[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
        end else if (adv2) begin
            rsp_valid <= s1_vld;
            if (s1_vld) begin
                rsp_sum  <= adder_sum;
                rsp_cout <= adder_cout;
                rsp_id   <= s1_q.id[IDW-1:0];
                rsp_last <= s1_q.last;
            end
        end
    end

    // id upper bits, first flag and last inputs are not needed in every build
    logic unused_bits;
    assign unused_bits = ^{s1_q.id, s1_q.first, sel_last, req_last};

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural external adder.
// Chained-add vs. plain scenario follows the ADDER_ARB_CHAIN_EN build.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_last;
    logic [W-1:0]      adder_a;
    logic [W-1:0]      adder_b;
    logic              adder_cin;
    logic [W-1:0]      adder_sum;
    logic              adder_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              rsp_last;

    logic [63:0] op_a [NREQ];
    logic [63:0] op_b [NREQ];

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [63:0] exp_sum [5] = '{64'h10, 64'h21, 64'h32, 64'h43, 64'h10};

    always #5 clk = ~clk;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    assign {adder_cout, adder_sum} =
        {1'b0, adder_a} + {1'b0, adder_b} + {64'd0, adder_cin};

    adder_arbiter #(
        .NREQ       (NREQ),
        .W          (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .req_last   (req_last),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_last   (rsp_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rsp_chk(input string tag, input logic [1:0] id,
                           input logic [63:0] sum, input logic cout,
                           input logic last);
        chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".id"},    64'(rsp_id),    64'(id));
        chk({tag, ".sum"},   rsp_sum,        sum);
        chk({tag, ".cout"},  64'(rsp_cout),  64'(cout));
        chk({tag, ".last"},  64'(rsp_last),  64'(last));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int i, input logic [63:0] a,
                           input logic [63:0] b, input logic cin,
                           input logic last);
        op_a[i]     = a;
        op_b[i]     = b;
        req_cin[i]  = cin;
        req_last[i] = last;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_cin   = '0;
        req_last  = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        step();
        step();
        rst = 1'b0;
        settle();

        // reset state
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.rsp_sum",   rsp_sum,        64'd0);
        chk("rst.rsp_id",    64'(rsp_id),    64'd0);
        chk("rst.rsp_cout",  64'(rsp_cout),  64'd0);
        chk("rst.rsp_last",  64'(rsp_last),  64'd0);
        step();

        // all four requesters streaming, one beat per cycle
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 64'h10 * 64'(i + 1), 64'(i), 1'b0, 1'b1);
        end
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5) ? 4'hF : 4'h0;
            settle();
            if (k < 5) begin
                chk($sformatf("rr.gnt%0d", k), 64'(req_ready), 64'(exp_gnt[k]));
            end
            if (k >= 2) begin
                rsp_chk($sformatf("rr.rsp%0d", k - 2), exp_id[k-2],
                        exp_sum[k-2], 1'b0, 1'b1);
            end else begin
                chk($sformatf("rr.idle%0d", k), 64'(rsp_valid), 64'd0);
            end
            step();
        end
        settle();
        chk("rr.drain", 64'(rsp_valid), 64'd0);
        step();

        // single request wraps to zero with carry out
        set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        req_valid = 4'b0100;
        settle();
        chk("one.ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        settle();
        chk("one.lat", 64'(rsp_valid), 64'd0);
        chk("one.adder_a", adder_a, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        settle();
        rsp_chk("one", 2'd2, 64'd0, 1'b1, 1'b1);
        step();
        settle();
        chk("one.drain", 64'(rsp_valid), 64'd0);
        step();

        // backpressure: two beats fill S1/S2, then ready drops
        set_req(0, 64'd5, 64'd7, 1'b0, 1'b1);
        set_req(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        settle();
        chk("bp.rdy0", 64'(req_ready), 64'b0001);
        step();
        settle();
        chk("bp.rdy1", 64'(req_ready), 64'b0010);
        chk("bp.vld1", 64'(rsp_valid), 64'd0);
        step();
        settle();
        chk("bp.rdy2", 64'(req_ready), 64'b0000);
        rsp_chk("bp.hold0", 2'd0, 64'hC, 1'b0, 1'b1);
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        settle();
        chk("bp.rdy3", 64'(req_ready), 64'b0000);
        rsp_chk("bp.rsp0", 2'd0, 64'hC, 1'b0, 1'b1);
        step();
        settle();
        rsp_chk("bp.rsp1", 2'd1, 64'd1, 1'b1, 1'b1);
        step();
        settle();
        chk("bp.drain", 64'(rsp_valid), 64'd0);
        step();

        // reset with both stages full (and a chain open on req2)
        set_req(2, 64'd1, 64'd1, 1'b0, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        settle();
        chk("rs.rdy0", 64'(req_ready), 64'b0100);
        step();
        settle();
        chk("rs.rdy1", 64'(req_ready), 64'b0100);
        step();
        settle();
        chk("rs.full", 64'(req_ready), 64'b0000);
        chk("rs.s2",   64'(rsp_valid), 64'd1);
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 64'd3, 64'd4, 1'b0, 1'b1);
        req_last  = '1;
        req_valid = 4'hF;
        settle();
        chk("rs.vld",   64'(rsp_valid), 64'd0);
        chk("rs.sum",   rsp_sum,        64'd0);
        chk("rs.grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        settle();
        chk("rs.drop", 64'(rsp_valid), 64'd0);
        step();
        settle();
        rsp_chk("rs.rsp", 2'd0, 64'd7, 1'b0, 1'b1);
        step();
        settle();
        chk("rs.drain", 64'(rsp_valid), 64'd0);
        step();

        // two-beat add on req1 while req0 keeps requesting
        set_req(0, 64'h100, 64'h23, 1'b1, 1'b1);
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        req_valid = 4'b0011;
        settle();
        chk("ch.gnt0", 64'(req_ready), 64'b0010);
        step();
        set_req(1, 64'd0, 64'd0, 1'b0, 1'b1);
`ifdef ADDER_ARB_CHAIN_EN
        settle();
        chk("ch.lock", 64'(req_ready), 64'b0010);
        step();
        req_valid = 4'b0001;
        settle();
        chk("ch.gnt2", 64'(req_ready), 64'b0001);
        rsp_chk("ch.b0", 2'd1, 64'd0, 1'b1, 1'b0);
        step();
        req_valid = '0;
        settle();
        rsp_chk("ch.b1", 2'd1, 64'd1, 1'b0, 1'b1);
        step();
        settle();
        rsp_chk("ch.r0", 2'd0, 64'h124, 1'b0, 1'b1);
        step();
`else
        settle();
        chk("nc.gnt1", 64'(req_ready), 64'b0001);
        step();
        settle();
        chk("nc.gnt2", 64'(req_ready), 64'b0010);
        rsp_chk("nc.b0", 2'd1, 64'd0, 1'b1, 1'b1);
        step();
        req_valid = '0;
        settle();
        rsp_chk("nc.r0", 2'd0, 64'h124, 1'b0, 1'b1);
        step();
        settle();
        rsp_chk("nc.b1", 2'd1, 64'd0, 1'b0, 1'b1);
        step();
`endif
        settle();
        chk("ch.drain", 64'(rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
